// File: rtl/maclaurin_pkg.sv
// Shared types and constants for the Maclaurin series evaluator.
// Coefficients are generated at elaboration time as round(2^w / denominator).
package maclaurin_pkg;

    typedef enum logic [1:0] {
        LN1P = 2'b00,
        EXP  = 2'b01,
        SIN  = 2'b10,
        COS  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        IDLE,
        SQR,
        ACC,
        POW,
        DONE
    } state_t;

    localparam int unsigned W_DEFAULT = 16;
    localparam logic [63:0] ONE_QW    = 64'd1 << W_DEFAULT;

    // Denominators stop growing once they exceed 4*2^w; the rounded
    // coefficient is already zero at that point, and this keeps 64 bits enough.
    function automatic logic [63:0] coef_calc(input mode_t m, input int k, input int w);
        logic [63:0] d;
        logic [63:0] lim;
        int          n;
        d   = 64'd1;
        lim = 64'd1 << (w + 2);
        n   = 0;
        if (k < 1) begin
            return 64'd0;
        end
        case (m)
            LN1P:    d = 64'(k);
            EXP:     n = k;
            SIN:     n = 2 * k - 1;
            default: n = 2 * k;
        endcase
        for (int i = 2; i <= 32; i++) begin
            if (i <= n && d < lim) begin
                d = d * 64'(i);
            end
        end
        return ((64'd1 << w) + (d >> 1)) / d;
    endfunction

endpackage

// File: rtl/maclaurin_coef_lut.sv
// Combinational coefficient table indexed by mode and term number, Q1.W unsigned.
// Every entry is an elaboration-time constant; entry 0 and entries past 15 terms are unused.
module maclaurin_coef_lut
    import maclaurin_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 4
) (
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] k,
    output logic [W:0]       coef
);

    localparam int DEPTH = 1 << CNT_W;

    logic [W:0] tbl [4][DEPTH];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        for (genvar j = 0; j < DEPTH; j++) begin : g_term
            assign tbl[m][j] = (W+1)'(coef_calc(mode_t'(2'(m)), j, W));
        end
    end

    assign coef = tbl[mode][k];

endmodule

// File: rtl/maclaurin_engine.sv
// Self-sequencing Maclaurin evaluator for ln(1+x), exp, sin, cos on one shared multiplier.
// done pulses 2*N_TERMS+1 cycles after start is accepted; start is ignored while busy.
module maclaurin_engine
    import maclaurin_pkg::*;
#(
    parameter int W       = 16,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [W-1:0]   x_in,
    output logic           busy,
    output logic           done,
    output logic [W+2:0]   result,
    output logic           ovf
);

    localparam logic [W+2:0] ACC_ONE  = (W+3)'((ONE_QW << W) >> W_DEFAULT);
    localparam logic [W+2:0] ACC_MAX  = {1'b0, {(W+2){1'b1}}};
    localparam logic [W+2:0] ACC_MIN  = {1'b1, {(W+2){1'b0}}};

    state_t              state;
    state_t              state_nx;
    mode_t               mode_r;
    mode_t               mode_in;
    logic [W-1:0]        xr;
    logic [W-1:0]        fr;
    logic [W-1:0]        pr;
    logic signed [W+2:0] acc;
    logic [CNT_W-1:0]    k;

    logic                accept;
    logic                last_term;
    logic [W:0]          coef;
    logic [W-1:0]        mul_a;
    logic [W:0]          mul_b;
    logic [W:0]          prod_hi;
    logic                sub;
    logic signed [W+3:0] acc_ext;
    logic signed [W+3:0] term_ext;
    logic signed [W+3:0] sum;
    logic                sat_hit;
    logic signed [W+2:0] acc_sat;

    assign mode_in   = mode_t'(mode);
    assign accept    = start && (state == IDLE || state == DONE);
    assign last_term = (k == CNT_W'(N_TERMS));

    maclaurin_coef_lut #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_coef (
        .mode (mode_r),
        .k    (k),
        .coef (coef)
    );

    // One multiplier serves squaring, term scaling and power stepping.
    always_comb begin
        mul_a = pr;
        mul_b = {1'b0, fr};
        case (state)
            SQR: begin
                mul_a = xr;
                mul_b = {1'b0, xr};
            end
            ACC:     mul_b = coef;
            default: ;
        endcase
    end

    assign prod_hi = (W+1)'(({{(W+1){1'b0}}, mul_a} * {{W{1'b0}}, mul_b}) >> W);

    always_comb begin
        sub = 1'b0;
        case (mode_r)
            LN1P, SIN: sub = ~k[0];
            EXP:       sub = 1'b0;
            COS:       sub = k[0];
            default:   sub = 1'b0;
        endcase
    end

    // Sum is one bit wider than acc so overflow shows as disagreeing top bits.
    always_comb begin
        acc_ext  = {acc[W+2], acc};
        term_ext = {3'b000, prod_hi};
        sum      = sub ? (acc_ext - term_ext) : (acc_ext + term_ext);
        sat_hit  = (sum[W+3] != sum[W+2]);
        acc_sat  = sum[W+2:0];
        if (sat_hit) begin
            acc_sat = sum[W+3] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SQR;
                end
            end
            SQR: begin
                busy     = 1'b1;
                state_nx = ACC;
            end
            ACC: begin
                busy     = 1'b1;
                state_nx = last_term ? DONE : POW;
            end
            POW: begin
                busy     = 1'b1;
                state_nx = ACC;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? SQR : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r <= LN1P;
            xr     <= '0;
            fr     <= '0;
            pr     <= '0;
            acc    <= '0;
            k      <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            mode_r <= mode_in;
            xr     <= x_in;
            fr     <= '0;
            pr     <= x_in;
            acc    <= (mode_in == EXP || mode_in == COS) ? ACC_ONE : '0;
            k      <= CNT_W'(1);
            ovf    <= 1'b0;
        end else begin
            case (state)
                SQR: begin
                    fr <= (mode_r == SIN || mode_r == COS) ? prod_hi[W-1:0] : xr;
                    if (mode_r == COS) begin
                        pr <= prod_hi[W-1:0];
                    end
                end
                ACC: begin
                    acc <= acc_sat;
                    if (sat_hit) begin
                        ovf <= 1'b1;
                    end
                    // Result is loaded on the way into DONE so it is valid with the pulse.
                    if (last_term) begin
                        result <= acc_sat;
                    end
                end
                POW: begin
                    pr <= prod_hi[W-1:0];
                    k  <= k + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maclaurin_engine.sv
// Directed bench for maclaurin_engine with a scoreboard fed by a plain-arithmetic series model.
module tb_maclaurin_engine;
    import maclaurin_pkg::*;

    localparam int W   = 16;
    localparam int N   = 8;
    localparam int LAT = 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic [W+2:0] result;
    logic         ovf;

    maclaurin_engine #(
        .W       (W),
        .N_TERMS (N)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .x_in   (x_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint due;
        longint res;
        logic   ov;
    } exp_t;

    exp_t   sb[$];
    longint cyc      = 0;
    int     n_cmp    = 0;
    int     n_fail   = 0;
    int     n_done   = 0;
    logic   chk_en   = 1'b0;
    longint last_res = 0;
    logic   last_ov  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_tol(input string nm, input longint act, input longint req, input longint tol);
        n_cmp++;
        if (act < req - tol || act > req + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, req, tol);
        end
    endtask

    // Coefficient straight from the series definition, using real arithmetic.
    function automatic longint coef_of(input int m, input int kk);
        real d;
        int  n;
        d = 1.0;
        if (m == 0) begin
            d = real'(kk);
        end else begin
            n = (m == 1) ? kk : (m == 2) ? 2 * kk - 1 : 2 * kk;
            for (int i = 2; i <= n; i++) d = d * i;
        end
        return longint'($rtoi(65536.0 / d + 0.5));
    endfunction

    function automatic longint model(input int m, input longint x, output logic ov);
        longint acc, sq, f, p, t;
        logic   neg;
        ov  = 1'b0;
        acc = (m == 1 || m == 3) ? 65536 : 0;
        sq  = (x * x) >> W;
        f   = (m >= 2) ? sq : x;
        p   = (m == 3) ? sq : x;
        for (int kk = 1; kk <= N; kk++) begin
            t   = (p * coef_of(m, kk)) >> W;
            neg = (m == 0 || m == 2) ? (kk % 2 == 0) : (m == 3) ? (kk % 2 == 1) : 1'b0;
            acc = neg ? acc - t : acc + t;
            if (acc > 262143) begin
                acc = 262143;
                ov  = 1'b1;
            end else if (acc < -262144) begin
                acc = -262144;
                ov  = 1'b1;
            end
            p = (p * f) >> W;
        end
        return acc;
    endfunction

    always @(negedge clk) begin : cmp
        logic bexp;
        if (chk_en) begin
            bexp = 1'b0;
            foreach (sb[i]) begin
                if (cyc >= sb[i].due - LAT + 1 && cyc < sb[i].due) bexp = 1'b1;
            end
            check("busy", longint'(busy), longint'(bexp));
            if (sb.size() != 0 && sb[0].due == cyc) begin
                check("done_timing", longint'(done), 1);
                if (done) begin
                    n_done++;
                    last_res = longint'($signed(result));
                    last_ov  = ovf;
                    check("result", last_res, sb[0].res);
                    check("ovf", longint'(ovf), longint'(sb[0].ov));
                end
                void'(sb.pop_front());
            end else if (done) begin
                n_done++;
                check("done_spurious", longint'(done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input longint x);
        exp_t e;
        logic o;
        e.due = cyc + LAT;
        e.res = model(m, x, o);
        e.ov  = o;
        sb.push_back(e);
    endtask

    task automatic run(input int m, input longint x);
        push(m, x);
        start = 1'b1;
        mode  = 2'(m);
        x_in  = W'(x);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        check("drain_timeout", longint'(sb.size()), 0);
        sb.delete();
    endtask

    initial begin
        longint c0;
        int     d0;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        x_in  = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_result", longint'(result), 0);
        chk_en = 1'b1;
        tick();

        run(1, 0);
        drain();
        check("exp0_literal", last_res, longint'(ONE_QW));
        check("exp0_ovf", longint'(last_ov), 0);

        run(0, 'h8000);
        drain();
        check_tol("ln1p_half_literal", last_res, 26563, 8);

        run(2, 'h8000);
        drain();
        check_tol("sin_half_literal", last_res, 31420, 4);

        run(3, 'h8000);
        drain();
        check_tol("cos_half_literal", last_res, 57513, 4);
        check("cos_half_ovf", longint'(last_ov), 0);

        run(1, 'hFFFF);
        drain();
        check_tol("exp_max_literal", last_res, 178138, 16);
        check("exp_max_ovf", longint'(last_ov), 0);

        // start pulses mid-run with different operands must be ignored
        d0 = n_done;
        c0 = cyc;
        run(2, 'h8000);
        while (cyc < c0 + 5) tick();
        start = 1'b1;
        mode  = 2'b11;
        x_in  = 16'h1234;
        tick();
        start = 1'b0;
        mode  = 2'b01;
        x_in  = 16'hF00F;
        while (cyc < c0 + 9) tick();
        start = 1'b1;
        mode  = 2'b00;
        tick();
        start = 1'b0;
        drain();
        check("ignored_start_done_count", longint'(n_done - d0), 1);
        check_tol("ignored_start_result", last_res, 31420, 4);

        // reset mid-run aborts without a done pulse
        d0 = n_done;
        c0 = cyc;
        run(1, 'hFFFF);
        while (cyc < c0 + 7) tick();
        rst = 1'b1;
        tick();
        sb.delete();
        check("abort_busy", longint'(busy), 0);
        check("abort_result", longint'(result), 0);
        check("abort_done", longint'(done), 0);
        rst = 1'b0;
        repeat (20) tick();
        check("abort_done_count", longint'(n_done - d0), 0);

        // start held through DONE chains a second run
        d0 = n_done;
        c0 = cyc;
        push(3, 'h8000);
        start = 1'b1;
        mode  = 2'b11;
        x_in  = 16'h8000;
        tick();
        while (cyc < c0 + LAT) tick();
        mode = 2'b01;
        x_in = 16'h4000;
        push(1, 'h4000);
        tick();
        start = 1'b0;
        drain();
        check("b2b_done_count", longint'(n_done - d0), 2);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
